// File: rtl/mix_sequencer.sv
// Time-multiplexed mixer: captures one frame of channel samples, runs a single MAC
// across the channels with per-channel gain, saturates and presents the sum on valid/ready.
module mix_sequencer #(
  parameter int NUM_INPUT_BITS  = 24,
  parameter int NUM_SIGNALS     = 4,
  parameter int GAIN_BITS       = 8,
  parameter int NUM_OUTPUT_BITS = 24
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_INPUT_BITS*NUM_SIGNALS-1:0] vol_data,
  input  logic                                  data_en,
  input  logic                                  gain_wr_en,
  input  logic [$clog2(NUM_SIGNALS)-1:0]        gain_wr_addr,
  input  logic [GAIN_BITS-1:0]                  gain_wr_data,
  output logic [NUM_OUTPUT_BITS-1:0]            mix_data,
  output logic                                  mix_valid,
  input  logic                                  mix_ready,
  output logic                                  busy,
  output logic                                  overrun
);
  localparam int CH_W   = $clog2(NUM_SIGNALS);
  localparam int PROD_W = NUM_INPUT_BITS + GAIN_BITS + 1;
  localparam int ACC_W  = NUM_INPUT_BITS + GAIN_BITS + CH_W + 1;
  localparam logic [GAIN_BITS-1:0] UNITY = GAIN_BITS'(1) << (GAIN_BITS - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX = (ACC_W'(1) << (NUM_OUTPUT_BITS - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic [1:0] {IDLE, ACCUM, SAT, OUT} state_t;

  state_t                                   r_state, w_state_nxt;
  logic [NUM_SIGNALS-1:0][NUM_INPUT_BITS-1:0] r_frame;
  logic [NUM_SIGNALS-1:0][GAIN_BITS-1:0]      r_gain_tab, r_gain_snap;
  logic signed [ACC_W-1:0]                  r_acc;
  logic [CH_W-1:0]                          r_ch;
  logic [NUM_OUTPUT_BITS-1:0]               r_mix_data;
  logic                                     r_mix_valid, r_busy, r_overrun;

  logic                                     w_capture, w_drop, w_last, w_hs;
  logic signed [PROD_W-1:0]                 w_prod;
  logic signed [ACC_W-1:0]                  w_prod_ext, w_shift, w_sat;

  assign w_hs       = r_mix_valid && mix_ready;
  assign w_last     = (r_ch == CH_W'(NUM_SIGNALS - 1));
  // Gain is unsigned: zero-extend so the signed multiply never sees it as negative.
  assign w_prod     = $signed(r_frame[r_ch]) * $signed({1'b0, r_gain_snap[r_ch]});
  assign w_prod_ext = w_prod;
  assign w_shift    = r_acc >>> (GAIN_BITS - 1);
  assign w_sat      = (w_shift > OUT_MAX) ? OUT_MAX :
                      (w_shift < OUT_MIN) ? OUT_MIN : w_shift;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      IDLE: if (data_en) begin
        w_capture   = 1'b1;
        w_state_nxt = ACCUM;
      end
      ACCUM: begin
        w_drop = data_en;
        if (w_last) w_state_nxt = SAT;
      end
      SAT: begin
        w_drop      = data_en;
        w_state_nxt = OUT;
      end
      OUT: begin
        if (w_hs) begin
          w_capture   = data_en;
          w_state_nxt = data_en ? ACCUM : IDLE;
        end else begin
          w_drop = data_en;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_frame     <= '0;
      r_gain_snap <= '0;
      r_acc       <= '0;
      r_ch        <= '0;
      r_mix_data  <= '0;
      r_mix_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= w_drop;
      r_busy    <= (w_state_nxt != IDLE);
      if (w_capture) begin
        r_frame     <= vol_data;
        r_gain_snap <= r_gain_tab;
        r_acc       <= '0;
        r_ch        <= '0;
      end else if (r_state == ACCUM) begin
        r_acc <= r_acc + w_prod_ext;
        r_ch  <= r_ch + 1'b1;
      end
      if (r_state == SAT) begin
        r_mix_data  <= w_sat[NUM_OUTPUT_BITS-1:0];
        r_mix_valid <= 1'b1;
      end else if (r_state == OUT && w_hs) begin
        r_mix_valid <= 1'b0;
      end
    end
  end

  // Table writes land on the next edge; a frame captured on that same edge keeps the old snapshot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NUM_SIGNALS; c++) r_gain_tab[c] <= UNITY;
    end else if (gain_wr_en && ({1'b0, gain_wr_addr} < (CH_W+1)'(NUM_SIGNALS))) begin
      r_gain_tab[gain_wr_addr] <= gain_wr_data;
    end
  end

  assign mix_data  = r_mix_data;
  assign mix_valid = r_mix_valid;
  assign busy      = r_busy;
  assign overrun   = r_overrun;
endmodule

// File: tb/tb_mix_sequencer.sv
// Directed bench for mix_sequencer: latency, gain, saturation, overrun, gain snapshot, reset abort.
module tb_mix_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] vol_data;
  logic        data_en, gain_wr_en, mix_ready;
  logic [1:0]  gain_wr_addr;
  logic [7:0]  gain_wr_data;
  logic [23:0] mix_data;
  logic        mix_valid, busy, overrun;

  int n_chk  = 0;
  int n_pass = 0;

  mix_sequencer dut (
    .clk(clk), .rst(rst), .vol_data(vol_data), .data_en(data_en),
    .gain_wr_en(gain_wr_en), .gain_wr_addr(gain_wr_addr), .gain_wr_data(gain_wr_data),
    .mix_data(mix_data), .mix_valid(mix_valid), .mix_ready(mix_ready),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_samples(input int s0, input int s1, input int s2, input int s3);
    vol_data = {24'(s3), 24'(s2), 24'(s1), 24'(s0)};
  endtask

  task automatic wr_gain(input logic [1:0] a, input logic [7:0] d);
    gain_wr_en = 1'b1; gain_wr_addr = a; gain_wr_data = d;
    tick();
    gain_wr_en = 1'b0;
  endtask

  // Caller raises data_en (and optionally a gain write); this clocks the capture edge,
  // waits (bounded) for mix_valid, checks latency and data, then clocks the handshake.
  task automatic run_frame(input string tag, input logic [23:0] exp);
    int n = 0;
    tick();
    data_en = 1'b0; gain_wr_en = 1'b0;
    while (!mix_valid && n < 12) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, 5);
    chk({tag, "_data"}, {8'h0, mix_data}, {8'h0, exp});
    tick();
    chk({tag, "_vld_clr"}, {31'h0, mix_valid}, 32'h0);
  endtask

  initial begin
    rst = 1'b0; data_en = 1'b0; gain_wr_en = 1'b0; gain_wr_addr = '0; gain_wr_data = '0;
    mix_ready = 1'b1; vol_data = '0;
    tick(); tick();
    chk("rst_data", {8'h0, mix_data}, 32'h0);
    chk("rst_valid", {31'h0, mix_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_ovr", {31'h0, overrun}, 32'h0);
    rst = 1'b1;
    tick();

    // 1: unity gains, exact timing
    set_samples(100, 200, -50, 10);
    data_en = 1'b1;
    tick();
    data_en = 1'b0;
    chk("t1_busy_T", {31'h0, busy}, 32'h1);
    repeat (4) tick();
    chk("t1_vld_T4", {31'h0, mix_valid}, 32'h0);
    chk("t1_busy_T4", {31'h0, busy}, 32'h1);
    tick();
    chk("t1_vld_T5", {31'h0, mix_valid}, 32'h1);
    chk("t1_data", {8'h0, mix_data}, 32'd260);
    chk("t1_busy_T5", {31'h0, busy}, 32'h1);
    tick();
    chk("t1_vld_T6", {31'h0, mix_valid}, 32'h0);
    chk("t1_busy_T6", {31'h0, busy}, 32'h0);

    // 2: half gain on ch1
    wr_gain(2'd1, 8'h40);
    set_samples(1000, 1000, 1000, 1000);
    data_en = 1'b1;
    run_frame("t2", 24'd3500);

    // 3: positive and negative saturation
    for (int c = 0; c < 4; c++) wr_gain(2'(c), 8'hFF);
    set_samples(32'h7FFFFF, 32'h7FFFFF, 32'h7FFFFF, 32'h7FFFFF);
    data_en = 1'b1;
    run_frame("t3_pos", 24'h7FFFFF);
    set_samples(32'h800000, 32'h800000, 32'h800000, 32'h800000);
    data_en = 1'b1;
    run_frame("t3_neg", 24'h800000);

    // 4: overrun in ACCUM and in stalled OUT, then handshake + capture together
    for (int c = 0; c < 4; c++) wr_gain(2'(c), 8'h80);
    mix_ready = 1'b0;
    set_samples(1, 2, 3, 4);
    data_en = 1'b1;
    tick();
    data_en = 1'b0;
    tick();
    set_samples(999, 999, 999, 999);
    data_en = 1'b1;
    tick();
    data_en = 1'b0;
    chk("t4_ovr_acc", {31'h0, overrun}, 32'h1);
    tick();
    chk("t4_ovr_clr1", {31'h0, overrun}, 32'h0);
    tick(); tick();
    chk("t4_vld", {31'h0, mix_valid}, 32'h1);
    chk("t4_data", {8'h0, mix_data}, 32'd10);
    set_samples(5, 5, 5, 5);
    data_en = 1'b1;
    tick();
    data_en = 1'b0;
    chk("t4_ovr_out", {31'h0, overrun}, 32'h1);
    chk("t4_hold_data", {8'h0, mix_data}, 32'd10);
    tick();
    chk("t4_ovr_clr2", {31'h0, overrun}, 32'h0);
    chk("t4_hold_vld", {31'h0, mix_valid}, 32'h1);
    mix_ready = 1'b1;
    data_en = 1'b1;
    run_frame("t4_next", 24'd20);
    chk("t4_no_ovr", {31'h0, overrun}, 32'h0);

    // 5: gain write on the capture edge is not seen by that frame
    set_samples(1000, 0, 0, 0);
    gain_wr_en = 1'b1; gain_wr_addr = 2'd0; gain_wr_data = 8'h00;
    data_en = 1'b1;
    run_frame("t5_old", 24'd1000);
    data_en = 1'b1;
    run_frame("t5_new", 24'd0);

    // 6: reset during the second ACCUM cycle
    set_samples(100, 200, -50, 10);
    data_en = 1'b1;
    tick();
    data_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("t6_busy", {31'h0, busy}, 32'h0);
    chk("t6_vld", {31'h0, mix_valid}, 32'h0);
    repeat (6) tick();
    chk("t6_no_out", {31'h0, mix_valid}, 32'h0);
    data_en = 1'b1;
    run_frame("t6_unity", 24'd260);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
